// File: rtl/psum_accumulate_writer.sv
// Generic FIFO: registered storage, head visible combinationally on dout.
// Latency: an entry pushed at edge N is poppable from the cycle after N.
// Backpressure: a push when full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         push_ok,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// Commits MAC results to BRAM port A, overwriting or read-modify-write accumulating per entry.
// Latency: push to BRAM write 2 edges (overwrite) or 4 edges (accumulate) when idle.
// Backpressure: none upstream; pushes into a full FIFO without a pop are dropped and flagged.
module psum_accumulate_writer #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 24,
    parameter int ACC_W      = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_validity,
    input  logic [ADDR_W-1:0] out_address,
    input  logic [DATA_W-1:0] out_data,
    input  logic              accumulate,
    input  logic              flush,
    output logic              fifo_full,
    output logic              overflow_err,
    output logic              flush_done,
    output logic              busy,
    output logic [15:0]       write_count,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [ACC_W-1:0]  bram_dina,
    input  logic [ACC_W-1:0]  bram_douta
);
    localparam int EW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [EW-1:0]     fifo_din;
    logic [EW-1:0]     fifo_dout;
    logic              fifo_empty;
    logic              push_ok;
    logic              pop;
    logic              w_acc;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  data_ext;
    logic              flush_pending;

    assign fifo_din = {accumulate, out_address, out_data};
    assign pop      = (state == S_IDLE) && !fifo_empty;
    assign data_ext = {{(ACC_W - DATA_W){w_data[DATA_W-1]}}, w_data};

    sync_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (data_validity),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .push_ok (push_ok),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Entries are fully serialized, so a later read always follows the prior write.
    always_comb begin
        state_nxt  = state;
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addra = '0;
        bram_dina  = '0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_nxt = fifo_dout[EW-1] ? S_READ : S_WRITE;
            end
            S_READ: begin
                bram_ena   = 1'b1;
                bram_addra = w_addr;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bram_ena   = 1'b1;
                bram_wea   = 1'b1;
                bram_addra = w_addr;
                bram_dina  = w_acc ? w_sum : data_ext;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_acc  <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
            w_sum  <= '0;
        end else begin
            if (pop) begin
                w_acc  <= fifo_dout[EW-1];
                w_addr <= fifo_dout[DATA_W +: ADDR_W];
                w_data <= fifo_dout[DATA_W-1:0];
            end
            if (state == S_WAIT) w_sum <= bram_douta + data_ext;
        end
    end

    assign busy       = !fifo_empty || (state != S_IDLE);
    assign flush_done = flush_pending && fifo_empty && (state == S_IDLE) && !push_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            write_count   <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (data_validity && !push_ok) overflow_err <= 1'b1;
            if (state == S_WRITE)          write_count  <= write_count + 16'd1;
            // A flush coinciding with completion is merged into it.
            if (flush_done)                flush_pending <= 1'b0;
            else if (flush)                flush_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_psum_accumulate_writer.sv
module tb_psum_accumulate_writer;
    localparam int ADDR_W     = 13;
    localparam int DATA_W     = 24;
    localparam int ACC_W      = 32;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              data_validity;
    logic [ADDR_W-1:0] out_address;
    logic [DATA_W-1:0] out_data;
    logic              accumulate;
    logic              flush;
    logic              fifo_full;
    logic              overflow_err;
    logic              flush_done;
    logic              busy;
    logic [15:0]       write_count;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic [ACC_W-1:0]  bram_dina;
    logic [ACC_W-1:0]  bram_douta;

    always #5 clk = ~clk;

    psum_accumulate_writer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_validity (data_validity),
        .out_address   (out_address),
        .out_data      (out_data),
        .accumulate    (accumulate),
        .flush         (flush),
        .fifo_full     (fifo_full),
        .overflow_err  (overflow_err),
        .flush_done    (flush_done),
        .busy          (busy),
        .write_count   (write_count),
        .bram_ena      (bram_ena),
        .bram_wea      (bram_wea),
        .bram_addra    (bram_addra),
        .bram_dina     (bram_dina),
        .bram_douta    (bram_douta)
    );

    // Read-first block RAM with a side port for preloading contents.
    logic [ACC_W-1:0]  bram [0:(1<<ADDR_W)-1];
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [ACC_W-1:0]  pre_dat;

    always @(posedge clk) begin
        if (pre_we) begin
            bram[pre_addr] <= pre_dat;
        end else if (bram_ena) begin
            bram_douta <= bram[bram_addra];
            if (bram_wea) bram[bram_addra] <= bram_dina;
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ACC_W-1:0]  d;
    } wr_t;

    logic [ACC_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
    wr_t              exp_q[$];
    logic [15:0]      exp_wc;
    int               checks   = 0;
    int               failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each accepted entry becomes one write, applied in arrival order.
    task automatic model_push(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt, input logic ac);
        logic [ACC_W-1:0] ext;
        logic [ACC_W-1:0] v;
        ext = ACC_W'(signed'(dt));
        v   = ac ? ref_mem[ad] + ext : ext;
        ref_mem[ad] = v;
        exp_q.push_back('{a: ad, d: v});
        exp_wc = exp_wc + 16'd1;
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && bram_ena && bram_wea) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", bram_addra, bram_dina);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(bram_addra), 64'(e.a));
                check("wr_data", 64'(bram_dina), 64'(e.d));
            end
        end
    end

    task automatic cyc(input logic v, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt,
                       input logic ac, input logic fl);
        data_validity = v;
        out_address   = ad;
        out_data      = dt;
        accumulate    = ac;
        flush         = fl;
        @(posedge clk);
        #1;
        data_validity = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy && k < 300) begin
            idle(1);
            k++;
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] ad, input logic [ACC_W-1:0] v);
        pre_we   = 1'b1;
        pre_addr = ad;
        pre_dat  = v;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
        ref_mem[ad] = v;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic              v;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              ra_acc;
        logic              rf;

        rst = 1'b1;
        data_validity = 1'b0;
        out_address = '0;
        out_data = '0;
        accumulate = 1'b0;
        flush = 1'b0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_dat = '0;
        exp_wc = '0;

        #12;
        check("rst_flags", 64'({fifo_full, overflow_err, flush_done, busy}), 64'd0);
        check("rst_wcount", 64'(write_count), 64'd0);
        check("rst_bram_ctl", 64'({bram_ena, bram_wea}), 64'd0);
        check("rst_bram_bus", 64'({bram_addra, bram_dina}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) preload(ADDR_W'(i), $urandom);
        preload(3, 32'd0);
        preload(7, 32'h64);
        for (int i = 100; i < 114; i++) preload(ADDR_W'(i), 32'd0);

        // Overwrite: write lands at the second edge after the push.
        model_push(5, 24'h000010, 1'b0);
        cyc(1'b1, 5, 24'h000010, 1'b0, 1'b0);
        check("ow_busy", 64'(busy), 64'd1);
        idle(1);
        check("ow_ctl", 64'({bram_ena, bram_wea}), 64'b11);
        check("ow_addr", 64'(bram_addra), 64'd5);
        check("ow_dina", 64'(bram_dina), 64'h10);
        idle(1);
        check("ow_wcount", 64'(write_count), 64'd1);
        check("ow_idle", 64'({bram_ena, busy}), 64'd0);

        // Negative accumulate: 0x64 + (-10).
        model_push(7, 24'hFFFFF6, 1'b1);
        cyc(1'b1, 7, 24'hFFFFF6, 1'b1, 1'b0);
        idle(1);
        check("acc_read_ctl", 64'({bram_ena, bram_wea}), 64'b10);
        check("acc_read_addr", 64'(bram_addra), 64'd7);
        idle(1);
        check("acc_wait_ctl", 64'(bram_ena), 64'd0);
        idle(1);
        check("acc_write_ctl", 64'({bram_ena, bram_wea}), 64'b11);
        check("acc_write_dina", 64'(bram_dina), 64'h5A);
        idle(1);
        check("acc_wcount", 64'(write_count), 64'd2);

        // Same address back-to-back accumulate.
        model_push(3, 24'd1, 1'b1);
        cyc(1'b1, 3, 24'd1, 1'b1, 1'b0);
        model_push(3, 24'd2, 1'b1);
        cyc(1'b1, 3, 24'd2, 1'b1, 1'b0);
        drain();
        check("same_addr_bram", 64'(bram[3]), 64'd3);
        check("same_addr_wcount", 64'(write_count), 64'(exp_wc));

        // Flush after three queued overwrites: third write at E6.
        for (int i = 0; i < 3; i++) begin
            model_push(ADDR_W'(40 + i), DATA_W'(i + 1), 1'b0);
            cyc(1'b1, ADDR_W'(40 + i), DATA_W'(i + 1), 1'b0, 1'b0);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) idle(1);
            check($sformatf("flush_done_e%0d", i + 3), 64'(flush_done), 64'(i == 3));
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("flush_idle", 64'(flush_done), 64'd1);
        idle(1);
        check("flush_idle_clr", 64'(flush_done), 64'd0);

        // Overflow: 14 accumulate pushes, E11/E12 dropped.
        for (int i = 0; i < 14; i++) begin
            if (i != 11 && i != 12) model_push(ADDR_W'(100 + i), DATA_W'(i + 1), 1'b1);
            cyc(1'b1, ADDR_W'(100 + i), DATA_W'(i + 1), 1'b1, 1'b0);
            if (i == 9)  check("ovf_full_e9", 64'(fifo_full), 64'd0);
            if (i == 10) check("ovf_full_e10", 64'(fifo_full), 64'd1);
            if (i == 10) check("ovf_err_e10", 64'(overflow_err), 64'd0);
            if (i == 11) check("ovf_err_e11", 64'(overflow_err), 64'd1);
        end
        drain();
        check("ovf_wcount", 64'(write_count), 64'(exp_wc));
        check("ovf_sticky", 64'(overflow_err), 64'd1);

        // Reset while in WAIT of an accumulate entry.
        cyc(1'b1, 20, 24'd5, 1'b1, 1'b0);
        idle(2);
        check("rst_mid_pre", 64'({bram_ena, busy}), 64'b01);
        rst = 1'b1;
        #1;
        check("rst_mid_ctl", 64'({bram_ena, bram_wea}), 64'd0);
        check("rst_mid_state", 64'({busy, fifo_full, overflow_err}), 64'd0);
        check("rst_mid_wcount", 64'(write_count), 64'd0);
        exp_wc = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        check("rst_post_wcount", 64'(write_count), 64'd0);
        check("rst_post_busy", 64'(busy), 64'd0);

        // Randomized traffic on a small address window to stress hazards.
        repeat (400) begin
            v      = ($urandom_range(0, 9) < 6) && !fifo_full;
            ra     = ADDR_W'($urandom_range(0, 7));
            rd     = DATA_W'($urandom);
            ra_acc = 1'($urandom_range(0, 1));
            rf     = ($urandom_range(0, 19) == 0);
            if (v) model_push(ra, rd, ra_acc);
            cyc(v, ra, rd, ra_acc, rf);
        end
        drain();
        check("rand_wcount", 64'(write_count), 64'(exp_wc));
        check("rand_no_ovf", 64'(overflow_err), 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("rand_bram_%0d", i), 64'(bram[i]), 64'(ref_mem[i]));
        idle(1);
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        check("final_flush", 64'(flush_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/psum_accumulate_writer.md
Name: psum_accumulate_writer

Overview:
- Sink end of the MAC result stream: consumes data_validity / out_address / out_data from queue_mac_controller and commits each result into the output-feature BRAM through port A.
- Per-entry mode: overwrite (first input-channel pass) or read-modify-write accumulate (later passes), enabling multi-pass convolution partial sums.
- An input FIFO absorbs producer bursts; a flush handshake tells the top-level sequencer that all results are committed.

Parameters:
ADDR_W, 13, output address width (matches out_address)
DATA_W, 24, incoming MAC result width (signed)
ACC_W, 32, stored partial-sum width in BRAM (signed)
FIFO_DEPTH, 8, input FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
data_validity  input  1  push strobe, one result per cycle when high
out_address  input  ADDR_W  result address, sampled with data_validity
out_data  input  DATA_W  signed result, sampled with data_validity
accumulate  input  1  sampled with data_validity: 0 overwrite, 1 add to stored value
flush  input  1  one-cycle request: report when all accepted entries are written
fifo_full  output  1  FIFO occupancy == FIFO_DEPTH (combinational from count)
overflow_err  output  1  sticky: a push was dropped
flush_done  output  1  one-cycle pulse, flush complete
busy  output  1  FIFO non-empty or FSM not IDLE
write_count  output  16  number of BRAM writes since reset, wraps
bram_ena  output  1  port A enable
bram_wea  output  1  port A write enable
bram_addra  output  ADDR_W  port A address
bram_dina  output  ACC_W  port A write data
bram_douta  input  ACC_W  port A read data, valid one cycle after the read edge

Behaviour:
- Reset (async, immediate): FIFO empty, FSM IDLE, overflow_err=0, flush_done=0, write_count=0, flush pending cleared, bram_ena=bram_wea=0, bram_addra=0, bram_dina=0. An in-flight entry is discarded.
- FIFO: entry = {accumulate, out_address, out_data}. A push is accepted when data_validity=1 and (not full, or a pop occurs in the same cycle). A push while full with no pop is dropped, and overflow_err sets and holds until reset.
- FSM: IDLE, READ, WAIT, WRITE. BRAM port outputs are combinational from state and working registers.
- IDLE: if FIFO non-empty, pop the head into working registers. Go to WRITE if its accumulate=0, otherwise to READ.
- READ: ena=1, wea=0, addra=entry address. Next state WAIT.
- WAIT: no BRAM access. At the end of the cycle, register sum = bram_douta + sign_extend(out_data). Next state WRITE.
- WRITE: ena=1, wea=1, addra=entry address. dina = sign_extend(data) for overwrite, or the registered sum for accumulate. write_count increments. Next state IDLE.
- Arithmetic: sign-extend DATA_W to ACC_W. Addition wraps modulo 2^ACC_W; no saturation.
- Latency: a push at edge E0 into an empty FIFO with FSM IDLE pops at E1. Overwrite: BRAM write at E2. Accumulate: read at E2, write at E4.
- Throughput: 2 cycles per entry (overwrite), 4 cycles per entry (accumulate).
- Same-address hazards: entries are fully serialized, so each read is issued at least one cycle after the prior write. No forwarding is needed.
- Flush: the flush pulse sets pending. When pending, FIFO empty, FSM IDLE and no push is accepted this cycle, assert flush_done for one cycle and clear pending. Any flush arriving while pending is merged.
- busy=0 only when FIFO is empty and FSM is IDLE.

Test Plan:
- Overwrite: push addr 5, data 0x000010, accumulate=0 at E0 -> at E2, wea=1, addra=5, dina=0x00000010; write_count=1.
- Negative accumulate: BRAM[7]=0x00000064, push addr 7, data 0xFFFFF6, accumulate=1 -> read addr 7 at E2; write at E4 with dina=0x0000005A.
- Same-address back-to-back: BRAM[3]=0, push (3, 1, acc) and (3, 2, acc) on consecutive cycles -> BRAM[3] ends at 3; write_count=2; the second read occurs after the first write.
- Overflow: 14 consecutive accumulate pushes into an idle block -> fifo_full at E10; pushes at E11 and E12 dropped; overflow_err=1 from E11; push at E13 accepted (concurrent pop); exactly 12 BRAM writes.
- Flush: 3 overwrite entries queued, flush pulse -> flush_done pulses once, the cycle after the third write returns the FSM to IDLE. Flush while idle and empty -> flush_done the next cycle.
- Reset mid-accumulate: assert rst during WAIT -> ena/wea drop immediately; FIFO empty; write_count=0; busy=0; no write issued after release.
